bird_sprite_drawer: RTL and testbench
=====================================

// Module: bird_sprite_drawer
// PURPOSE
//  Downstream of the bird control FSM. Takes each new bird y from the control FSM.
//  Erases the old SPRITE_W x SPRITE_H bird at the fixed column BIRD_X, then draws it at the new y.
//  Emits one pixel per clk as plot/x/y/colour for the VGA adapter's framebuffer write port.
//  Only the 4x4 bird rectangle is ever touched; pipes and background are owned by other blocks.
// PARAMETERS
//  BIRD_X      20      fixed left column of the sprite
//  SPRITE_W    4       sprite width, pixels (>=1)
//  SPRITE_H    4       sprite height, pixels (>=1)
//  SCREEN_H    120     visible rows; y range 0..SCREEN_H-1
//  BIRD_COL    3'b010  sprite colour (green)
//  BG_COL      3'b000  erase colour (black)
// PORTS
//  clk       in   1  system clock, the one clock; all state on posedge clk
//  resetn    in   1  asynchronous, active-low reset
//  y_valid   in   1  new bird y offered this cycle
//  y_in      in   7  requested top row of sprite
//  ready     out  1  1 when idle and a y_valid will be accepted
//  plot      out  1  framebuffer write enable for this cycle
//  x_out     out  8  pixel column
//  y_out     out  7  pixel row
//  colour    out  3  pixel colour
//  done      out  1  one-cycle pulse when a requested update has fully completed
// BEHAVIOUR
//  Reset (async): state=IDLE, cur_y=0, drawn=0, counters=0; ready=1, plot=0, done=0, x_out=0, y_out=0, colour=0.
//  Accept: the handshake completes on a posedge with y_valid&&ready.
//   The block latches new_y = min(y_in, SCREEN_H-SPRITE_H); larger values are clamped, never wrapped.
//   y_valid while ready=0 is ignored; nothing is queued.
//  FSM: IDLE -> ERASE | DRAW | FINISH; ERASE -> DRAW; DRAW -> FINISH; FINISH -> IDLE.
//   On accept: if !drawn, go to DRAW.
//              else if new_y==cur_y, go to FINISH with no pixels written.
//              else go to ERASE.
//   ERASE: exactly SPRITE_W*SPRITE_H cycles, plot=1, colour=BG_COL, rows based at cur_y.
//   DRAW: exactly SPRITE_W*SPRITE_H cycles, plot=1, colour=BIRD_COL, rows based at new_y.
//    On DRAW exit: cur_y<=new_y, drawn<=1.
//   FINISH: 1 cycle, done=1, ready=0; then IDLE with ready=1.
//  Scan order: row-major, column fastest. x_out=BIRD_X+cx, y_out=base+cy.
//   cx runs 0..SPRITE_W-1; cy increments when cx wraps.
//   Both counters clear when ERASE or DRAW is entered.
//  Outputs are a Moore decode of registered state and counters, so each pixel is valid for its whole cycle.
//   Outside ERASE/DRAW: plot=0; x_out/y_out/colour are don't-care but held stable.
//  Latency, accept to done (done counted as the final cycle):
//   moving update 2*N+1 cycles, first draw N+1, same-y 1; N=SPRITE_W*SPRITE_H (=16).
//  Reset mid-operation: aborts at once, no further plot. drawn=0, so the next accept does a full DRAW.
//   Any partially erased or drawn pixels are left as they are.
//  Widths: x sum is 8 bits; BIRD_X+SPRITE_W-1 must be <=159.
//   y sum is 7 bits; clamping guarantees no overflow.
// STRUCTURE
//  Shared package bird_pkg holds:
//   screen dims (SCREEN_W=160, SCREEN_H=120), BIRD_X, colour constants (BLACK, GREEN);
//   a drw_state_t enum {IDLE, ERASE, DRAW, FINISH}.
//  One sub-module, rect_scanner: parameterised W/H counter with start and step inputs and cx, cy, last outputs.
//   Instantiated once and reused by ERASE and DRAW.
//  The top level contains only the FSM, the cur_y/new_y/drawn registers and the output decode.
// TESTING
//  1. Reset, then y_valid=1, y_in=60. Expect ready to drop, no erase pixels, then 16 green plots.
//     Plots cover x=20..23, y=60..63 row-major; done after 17 cycles.
//  2. Then y_in=56. Expect 16 black plots at y=60..63, then 16 green plots at y=56..59; done after 33 cycles.
//  3. Then y_in=56 again. Expect no plots; done pulses 1 cycle after accept.
//  4. y_in=127. Expect the value clamped to 116: green at y=116..119 and no y_out>119 ever.
//  5. During DRAW, y_valid=1 with y_in=10. Expect it ignored: the drawing is unchanged and ready=0 until FINISH ends.
//  6. Assert resetn=0 on the 5th cycle of ERASE. Expect plot=0 on the same edge.
//     Then y_in=30 gives 16 green plots at y=30..33 with no erase.
//  Checker: scoreboard of a 160x120 shadow framebuffer. After each done, only the 4x4 at cur_y is BIRD_COL.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared constants and state type for the bird sprite drawer.
// Screen geometry, default sprite placement and palette entries live here.
package bird_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BIRD_X   = 20;
  localparam int SPRITE_W = 4;
  localparam int SPRITE_H = 4;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ERASE  = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } drw_state_t;

endpackage

// File: rtl/bird_sprite_drawer_if.sv
// Bundle between the bird control FSM (master) and the sprite drawer (slave).
// Carries the y request handshake and the framebuffer pixel write stream.
interface bird_sprite_drawer_if;

  logic       y_valid;
  logic [6:0] y_in;
  logic       ready;
  logic       plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       done;

  modport master (
    output y_valid, y_in,
    input  ready, plot, x_out, y_out, colour, done
  );

  modport slave (
    input  y_valid, y_in,
    output ready, plot, x_out, y_out, colour, done
  );

endinterface

// File: rtl/rect_scanner.sv
// Row-major W x H position counter: cx runs fastest, cy advances when cx wraps.
// start clears both counters and wins over step.
module rect_scanner #(
  parameter  int W   = 4,
  parameter  int H   = 4,
  localparam int CXW = (W > 1) ? $clog2(W) : 1,
  localparam int CYW = (H > 1) ? $clog2(H) : 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start_i,
  input  logic           step_i,
  output logic [CXW-1:0] cx_o,
  output logic [CYW-1:0] cy_o,
  output logic           last_o
);

  localparam logic [CXW-1:0] CX_MAX = CXW'(W - 1);
  localparam logic [CYW-1:0] CY_MAX = CYW'(H - 1);

  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (start_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (step_i) begin
      if (cx_q == CX_MAX) begin
        cx_d = '0;
        cy_d = (cy_q == CY_MAX) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign last_o = (cx_q == CX_MAX) && (cy_q == CY_MAX);

endmodule

// File: rtl/bird_sprite_drawer.sv
// Erases the bird at its old row and redraws it at the newly requested row,
// streaming one framebuffer write per cycle; only the sprite rectangle is touched.
module bird_sprite_drawer
  import bird_pkg::*;
#(
  parameter int         BIRD_X   = bird_pkg::BIRD_X,
  parameter int         SPRITE_W = bird_pkg::SPRITE_W,
  parameter int         SPRITE_H = bird_pkg::SPRITE_H,
  parameter int         SCREEN_H = bird_pkg::SCREEN_H,
  parameter logic [2:0] BIRD_COL = bird_pkg::GREEN,
  parameter logic [2:0] BG_COL   = bird_pkg::BLACK
) (
  input  logic                 clk,
  input  logic                 resetn,
  bird_sprite_drawer_if.slave  bus
);

  localparam int         CXW   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int         CYW   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [6:0] Y_MAX = 7'(SCREEN_H - SPRITE_H);

  drw_state_t state_q, state_d;
  logic [6:0] cur_y_q, cur_y_d;
  logic [6:0] new_y_q, new_y_d;
  logic       drawn_q, drawn_d;

  logic           scan_start;
  logic           scan_step;
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic           scan_last;
  logic [6:0]     y_clamped;

  rect_scanner #(
    .W (SPRITE_W),
    .H (SPRITE_H)
  ) u_scanner (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (scan_start),
    .step_i  (scan_step),
    .cx_o    (cx),
    .cy_o    (cy),
    .last_o  (scan_last)
  );

  // Out-of-range rows saturate at the lowest position that keeps the sprite on screen.
  assign y_clamped = (bus.y_in > Y_MAX) ? Y_MAX : bus.y_in;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cur_y_q <= '0;
      new_y_q <= '0;
      drawn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_y_q <= cur_y_d;
      new_y_q <= new_y_d;
      drawn_q <= drawn_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_y_d    = cur_y_q;
    new_y_d    = new_y_q;
    drawn_d    = drawn_q;
    scan_start = 1'b0;
    scan_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.y_valid) begin
          new_y_d = y_clamped;
          if (!drawn_q) begin
            state_d    = DRAW;
            scan_start = 1'b1;
          end else if (y_clamped == cur_y_q) begin
            state_d = FINISH;
          end else begin
            state_d    = ERASE;
            scan_start = 1'b1;
          end
        end
      end
      ERASE: begin
        scan_step = 1'b1;
        if (scan_last) begin
          state_d    = DRAW;
          scan_start = 1'b1;
        end
      end
      DRAW: begin
        scan_step = 1'b1;
        if (scan_last) begin
          state_d = FINISH;
          cur_y_d = new_y_q;
          drawn_d = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel outputs decode only registered state, so each write is stable for a full cycle.
  always_comb begin
    bus.ready  = (state_q == IDLE);
    bus.done   = (state_q == FINISH);
    bus.plot   = 1'b0;
    bus.x_out  = '0;
    bus.y_out  = '0;
    bus.colour = '0;
    if (state_q == ERASE) begin
      bus.plot   = 1'b1;
      bus.x_out  = 8'(BIRD_X) + 8'(cx);
      bus.y_out  = cur_y_q + 7'(cy);
      bus.colour = BG_COL;
    end else if (state_q == DRAW) begin
      bus.plot   = 1'b1;
      bus.x_out  = 8'(BIRD_X) + 8'(cx);
      bus.y_out  = new_y_q + 7'(cy);
      bus.colour = BIRD_COL;
    end
  end

endmodule

// File: tb/tb_bird_sprite_drawer.sv
// Bench for bird_sprite_drawer: directed and random y updates checked against a
// pixel-list model and a shadow framebuffer built from observed writes.
module tb_bird_sprite_drawer;

  localparam int N     = 16;
  localparam int Y_TOP = 116;
  localparam logic [2:0] GRN = 3'b010;
  localparam logic [2:0] BLK = 3'b000;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  bird_sprite_drawer_if ifc ();

  bird_sprite_drawer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int oob_cnt = 0;

  logic [2:0] shadow    [0:159][0:119];
  logic [2:0] expect_fb [0:159][0:119];

  bit   m_drawn;
  int   m_cur_y;
  bit   fb_clean;
  pix_t exp_q[$];

  always @(negedge clk) begin
    if (resetn === 1'b1 && ifc.plot === 1'b1) begin
      if (ifc.x_out >= 8'd160 || ifc.y_out >= 7'd120) oob_cnt++;
      else shadow[ifc.x_out][ifc.y_out] = ifc.colour;
    end
  end

  function automatic void push_rect(input int base, input logic [2:0] c);
    pix_t p;
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++) begin
        p.x = 20 + xx;
        p.y = base + yy;
        p.c = c;
        exp_q.push_back(p);
      end
  endfunction

  // One request: model predicts pixel list and latency, bench checks every cycle.
  task automatic run_update(input int yin, input string name, input int inject_at, input int reset_at);
    int ny, lat, cycles, pidx, bad_ready, fb_bad, greens, stray, nexp;
    bit saw_done;
    ny = (yin > Y_TOP) ? Y_TOP : yin;
    exp_q.delete();
    if (!m_drawn) begin
      push_rect(ny, GRN);
      lat = N + 1;
    end else if (ny == m_cur_y) begin
      lat = 1;
    end else begin
      push_rect(m_cur_y, BLK);
      push_rect(ny, GRN);
      lat = 2 * N + 1;
    end

    @(negedge clk);
    n_cmp++;
    if (ifc.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_before_accept got=%b want=1", name, ifc.ready);
    end
    ifc.y_valid = 1'b1;
    ifc.y_in    = 7'(yin);
    @(negedge clk);
    ifc.y_valid = 1'b0;
    cycles = 1; pidx = 0; bad_ready = 0; saw_done = 0;
    while (cycles <= 100) begin
      if (ifc.ready !== 1'b0) bad_ready++;
      if (ifc.plot === 1'b1) begin
        n_cmp++;
        if (pidx >= exp_q.size()) begin
          n_bad++;
          $display("FAIL %s extra_plot idx=%0d got x=%0d y=%0d c=%0d want none",
                   name, pidx, ifc.x_out, ifc.y_out, ifc.colour);
        end else if (ifc.x_out !== 8'(exp_q[pidx].x) || ifc.y_out !== 7'(exp_q[pidx].y) ||
                     ifc.colour !== exp_q[pidx].c) begin
          n_bad++;
          $display("FAIL %s pixel idx=%0d got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                   name, pidx, ifc.x_out, ifc.y_out, ifc.colour,
                   exp_q[pidx].x, exp_q[pidx].y, exp_q[pidx].c);
        end
        pidx++;
      end
      if (reset_at == cycles) begin
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (ifc.plot !== 1'b0 || ifc.ready !== 1'b1) begin
          n_bad++;
          $display("FAIL %s plot_on_reset got plot=%b ready=%b want plot=0 ready=1",
                   name, ifc.plot, ifc.ready);
        end
        break;
      end
      if (ifc.done === 1'b1) begin
        saw_done = 1'b1;
        break;
      end
      if (inject_at == cycles) begin
        ifc.y_valid = 1'b1;
        ifc.y_in    = 7'd10;
      end else begin
        ifc.y_valid = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    ifc.y_valid = 1'b0;

    nexp = (reset_at > 0) ? reset_at : exp_q.size();
    for (int i = 0; i < nexp && i < exp_q.size(); i++)
      expect_fb[exp_q[i].x][exp_q[i].y] = exp_q[i].c;

    n_cmp++;
    if (pidx !== nexp) begin
      n_bad++;
      $display("FAIL %s plot_count got=%0d want=%0d", name, pidx, nexp);
    end
    n_cmp++;
    if (bad_ready != 0) begin
      n_bad++;
      $display("FAIL %s ready_while_busy got=%0d_cycles_high want=0", name, bad_ready);
    end

    if (reset_at > 0) begin
      m_drawn  = 1'b0;
      m_cur_y  = 0;
      fb_clean = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
    end else begin
      n_cmp++;
      if (!saw_done || cycles != lat) begin
        n_bad++;
        $display("FAIL %s latency got=%0d done=%b want=%0d", name, cycles, saw_done, lat);
      end
      m_drawn = 1'b1;
      m_cur_y = ny;
    end

    fb_bad = 0; greens = 0; stray = 0;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++) begin
        if (shadow[x][y] !== expect_fb[x][y]) fb_bad++;
        if (shadow[x][y] === GRN) begin
          greens++;
          if (x < 20 || x > 23 || y < m_cur_y || y > m_cur_y + 3) stray++;
        end
      end
    n_cmp++;
    if (fb_bad != 0) begin
      n_bad++;
      $display("FAIL %s framebuffer got=%0d_diff_pixels want=0", name, fb_bad);
    end
    if (fb_clean && reset_at == 0) begin
      n_cmp++;
      if (greens != 16 || stray != 0) begin
        n_bad++;
        $display("FAIL %s sprite_only got greens=%0d stray=%0d want greens=16 stray=0",
                 name, greens, stray);
      end
    end
    $display("txn %-10s y_in=%0d new_y=%0d plots=%0d cycles=%0d cur_y=%0d",
             name, yin, ny, pidx, cycles, m_cur_y);
  endtask

  task automatic test_reset();
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++) begin
        shadow[x][y]    = BLK;
        expect_fb[x][y] = BLK;
      end
    m_drawn = 1'b0; m_cur_y = 0; fb_clean = 1'b1;
    ifc.y_valid = 1'b0;
    ifc.y_in    = 7'd0;
    resetn      = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ifc.ready !== 1'b1 || ifc.plot !== 1'b0 || ifc.done !== 1'b0 ||
        ifc.x_out !== 8'd0 || ifc.y_out !== 7'd0 || ifc.colour !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got r=%b p=%b d=%b x=%0d y=%0d c=%0d want r=1 p=0 d=0 x=0 y=0 c=0",
               ifc.ready, ifc.plot, ifc.done, ifc.x_out, ifc.y_out, ifc.colour);
    end
    resetn = 1'b1;
    $display("txn reset      outputs checked");
  endtask

  task automatic test_first_draw();   run_update(60,  "first",  0, 0);  endtask
  task automatic test_move();         run_update(56,  "move",   0, 0);  endtask
  task automatic test_same_y();       run_update(56,  "same_y", 0, 0);  endtask
  task automatic test_clamp();        run_update(127, "clamp",  0, 0);  endtask
  task automatic test_ignore_busy();  run_update(80,  "ignore", 20, 0); endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) v = m_cur_y;
      else v = int'($urandom_range(0, 127));
      run_update(v, "random", 0, 0);
    end
  endtask

  task automatic test_reset_mid_erase();
    run_update((m_cur_y + 20) % 100, "abort", 0, 5);
    run_update(30, "redraw", 0, 0);
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_move();
    test_same_y();
    test_clamp();
    test_ignore_busy();
    test_random();
    test_reset_mid_erase();
    n_cmp++;
    if (oob_cnt != 0) begin
      n_bad++;
      $display("FAIL out_of_range_writes got=%0d want=0", oob_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
